// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pool; pooled pixel is registered on the edge that samples the window's last pixel.
// MAXPOOL_FUSED_RELU_EN: when defined, negative pooled results are clamped to zero.
module maxpool2x2_stream #(
   parameter int dataWidth = 16,
   parameter int imgWidth  = 28,
   parameter int imgHeight = 28
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [dataWidth-1:0] x_i,
   input  logic                 inValid_i,
   output logic [dataWidth-1:0] out_o,
   output logic                 outValid_o,
   output logic                 frameDone_o
);

   localparam int HalfW = imgWidth / 2;
   localparam int ColW  = (imgWidth > 1) ? $clog2(imgWidth) : 1;
   localparam int RowW  = (imgHeight > 1) ? $clog2(imgHeight) : 1;
   localparam int BufW  = (HalfW > 1) ? $clog2(HalfW) : 1;

   logic [ColW-1:0]      col_q, col_d;
   logic [RowW-1:0]      row_q, row_d;
   logic [dataWidth-1:0] hold_q, hold_d;
   logic [dataWidth-1:0] out_q, out_d;
   logic                 outValid_q, outValid_d;
   logic                 frameDone_q, frameDone_d;

   logic [dataWidth-1:0] line_buf [HalfW];
   logic [BufW-1:0]      buf_idx;
   logic [dataWidth-1:0] pair_max;
   logic [dataWidth-1:0] win_max;
   logic [dataWidth-1:0] pool_res;
   logic                 col_last;
   logic                 row_last;

   assign buf_idx  = BufW'(col_q >> 1);
   assign col_last = (col_q == ColW'(imgWidth - 1));
   assign row_last = (row_q == RowW'(imgHeight - 1));
   assign pair_max = ($signed(hold_q) > $signed(x_i)) ? hold_q : x_i;
   assign win_max  = ($signed(pair_max) > $signed(line_buf[buf_idx])) ? pair_max : line_buf[buf_idx];

`ifdef MAXPOOL_FUSED_RELU_EN
   assign pool_res = win_max[dataWidth-1] ? '0 : win_max;
`else
   assign pool_res = win_max;
`endif

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      hold_d      = hold_q;
      out_d       = out_q;
      outValid_d  = 1'b0;
      frameDone_d = 1'b0;
      if (inValid_i) begin
         if (!col_q[0]) begin
            hold_d = x_i;
         end else if (row_q[0]) begin
            out_d       = pool_res;
            outValid_d  = 1'b1;
            frameDone_d = col_last && row_last;
         end
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         hold_q      <= '0;
         out_q       <= '0;
         outValid_q  <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         hold_q      <= hold_d;
         out_q       <= out_d;
         outValid_q  <= outValid_d;
         frameDone_q <= frameDone_d;
      end
   end

   // Every entry is rewritten in an even row before the odd row reads it, so no reset is needed.
   always_ff @(posedge clk) begin
      if (inValid_i && col_q[0] && !row_q[0]) begin
         line_buf[buf_idx] <= pair_max;
      end
   end

   assign out_o       = out_q;
   assign outValid_o  = outValid_q;
   assign frameDone_o = frameDone_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: instance 0 is 2x2, instance 1 is 4x4, instance 2 is the default 28x28.
module tb_maxpool2x2_stream;

`ifdef MAXPOOL_FUSED_RELU_EN
   localparam bit FusedRelu = 1'b1;
`else
   localparam bit FusedRelu = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  inst;
      logic [15:0] dat;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] xin [3];
   logic        vin [3];
   logic [15:0] o   [3];
   logic        ov  [3];
   logic        fd  [3];

   int          n_checks = 0;
   int          n_fails  = 0;
   exp_t        sbq[$];
   logic [15:0] got1[$];
   logic [15:0] img [3][28][28];
   int          r [3];
   int          c [3];
   int          wid [3] = '{2, 4, 28};
   bit          br [3];
   int          n_out [3];
   int          n_fd [3];
   logic [15:0] last_o [3];

   always #5 clk = ~clk;

   maxpool2x2_stream #(.dataWidth(16), .imgWidth(2), .imgHeight(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .x_i(xin[0]), .inValid_i(vin[0]),
      .out_o(o[0]), .outValid_o(ov[0]), .frameDone_o(fd[0]));

   maxpool2x2_stream #(.dataWidth(16), .imgWidth(4), .imgHeight(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .x_i(xin[1]), .inValid_i(vin[1]),
      .out_o(o[1]), .outValid_o(ov[1]), .frameDone_o(fd[1]));

   maxpool2x2_stream #(.dataWidth(16), .imgWidth(28), .imgHeight(28)) u_dut28 (
      .clk(clk), .rst_n(rst_n), .x_i(xin[2]), .inValid_i(vin[2]),
      .out_o(o[2]), .outValid_o(ov[2]), .frameDone_o(fd[2]));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   // One cycle of stimulus; a window's expected result is pushed when its bottom-right pixel is driven.
   task automatic step(input int k, input bit valid, input logic [15:0] v);
      logic [15:0] m;
      exp_t        e;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         vin[j] = 1'b0;
         br[j]  = 1'b0;
      end
      xin[k] = v;
      vin[k] = valid;
      if (valid) begin
         img[k][r[k]][c[k]] = v;
         if ((r[k] % 2 == 1) && (c[k] % 2 == 1)) begin
            m = smax(smax(img[k][r[k]-1][c[k]-1], img[k][r[k]-1][c[k]]),
                     smax(img[k][r[k]][c[k]-1], img[k][r[k]][c[k]]));
            if (FusedRelu && m[15]) m = 16'h0000;
            e.inst = 2'(k);
            e.dat  = m;
            e.last = (r[k] == wid[k] - 1) && (c[k] == wid[k] - 1);
            sbq.push_back(e);
            br[k] = 1'b1;
         end
         c[k]++;
         if (c[k] == wid[k]) begin
            c[k] = 0;
            r[k]++;
            if (r[k] == wid[k]) r[k] = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 1'b0, 16'($urandom));
   endtask

   task automatic frame4(input int base, input bit gaps);
      for (int p = 0; p < 16; p++) begin
         while (gaps && ($urandom_range(1, 0) == 1)) step(1, 1'b0, 16'($urandom));
         step(1, 1'b1, 16'(base + p));
      end
   endtask

   task automatic check_got(input string tag, input int base, input int idx);
      int ramp [4] = '{5, 7, 13, 15};
      for (int i = 0; i < 4; i++) begin
         if (got1.size() > idx + i) check_eq(tag, 32'(got1[idx + i]), 32'(base + ramp[i]));
         else check_eq({tag, "_count"}, 32'(got1.size()), 32'(idx + i + 1));
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      for (int k = 0; k < 3; k++) begin
         if (rst_n) begin
            if (ov[k]) begin
               check_eq($sformatf("latency%0d", k), 32'(br[k]), 32'd1);
               if (sbq.size() == 0) begin
                  check_eq($sformatf("unexpected%0d", k), 32'(ov[k]), 32'd0);
               end else begin
                  e = sbq.pop_front();
                  check_eq($sformatf("inst%0d", k), 32'(k), 32'(e.inst));
                  check_eq($sformatf("out%0d", k), 32'(o[k]), 32'(e.dat));
                  check_eq($sformatf("frameDone%0d", k), 32'(fd[k]), 32'(e.last));
               end
               n_out[k]++;
               if (fd[k]) n_fd[k]++;
               if (k == 1) got1.push_back(o[k]);
            end else begin
               check_eq($sformatf("stable%0d", k), 32'(o[k]), 32'(last_o[k]));
               check_eq($sformatf("fdAlone%0d", k), 32'(fd[k]), 32'd0);
               if (br[k]) check_eq($sformatf("missing%0d", k), 32'(ov[k]), 32'd1);
            end
         end
         last_o[k] = o[k];
      end
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         xin[k] = '0; vin[k] = 1'b0; r[k] = 0; c[k] = 0; br[k] = 1'b0;
         n_out[k] = 0; n_fd[k] = 0;
      end
      #3;
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("rst_out%0d", k), 32'(o[k]), 32'd0);
         check_eq($sformatf("rst_ov%0d", k), 32'(ov[k]), 32'd0);
         check_eq($sformatf("rst_fd%0d", k), 32'(fd[k]), 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Ramp
      got1.delete();
      frame4(0, 1'b0);
      idle(3);
      check_got("ramp", 0, 0);
      check_eq("ramp_nout", 32'(n_out[1]), 32'd4);
      check_eq("ramp_nfd", 32'(n_fd[1]), 32'd1);

      // Negatives on the 2x2 instance
      step(0, 1'b1, 16'hFFFD);
      step(0, 1'b1, 16'hFFFF);
      step(0, 1'b1, 16'hFFF9);
      step(0, 1'b1, 16'hFFFE);
      idle(3);
      check_eq("neg_out", 32'(o[0]), FusedRelu ? 32'h0000 : 32'hFFFF);
      check_eq("neg_nfd", 32'(n_fd[0]), 32'd1);

      // Gaps
      got1.delete();
      frame4(0, 1'b1);
      idle(3);
      check_got("gaps", 0, 0);
      check_eq("gaps_nfd", 32'(n_fd[1]), 32'd2);

      // Reset mid-frame after 9 pixels
      for (int p = 0; p < 9; p++) step(1, 1'b1, 16'(p));
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         vin[j] = 1'b0;
         br[j]  = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out", 32'(o[1]), 32'd0);
      check_eq("midrst_ov", 32'(ov[1]), 32'd0);
      check_eq("midrst_fd", 32'(fd[1]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check_eq("midrst_out_hold", 32'(o[1]), 32'd0);
      r[1] = 0;
      c[1] = 0;
      sbq.delete();
      rst_n = 1'b1;
      got1.delete();
      frame4(0, 1'b0);
      idle(3);
      check_got("afterrst", 0, 0);
      check_eq("afterrst_count", 32'(got1.size()), 32'd4);
      check_eq("afterrst_nfd", 32'(n_fd[1]), 32'd3);

      // Back-to-back frames
      got1.delete();
      frame4(0, 1'b0);
      frame4(100, 1'b0);
      idle(3);
      check_got("b2b_a", 0, 0);
      check_got("b2b_b", 100, 4);
      check_eq("b2b_nfd", 32'(n_fd[1]), 32'd5);

      // Default-size random frame
      for (int p = 0; p < 28 * 28; p++) step(2, 1'b1, 16'($urandom));
      idle(3);
      check_eq("big_nout", 32'(n_out[2]), 32'd196);
      check_eq("big_nfd", 32'(n_fd[2]), 32'd1);

      check_eq("sb_drained", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the ReLU activation in each convolution channel. It consumes one activated pixel per valid cycle in raster order, keeps a half-width line buffer of horizontal pair maxima, and emits one pooled pixel per 2×2 window. It uses the same valid-only streaming convention as the activation stage: no backpressure, every valid input is accepted.

## Interface
- `dataWidth`, default 16: pixel width, two's complement.
- `imgWidth`, default 28: input columns per row. Must be even and ≥ 2.
- `imgHeight`, default 28: input rows per frame. Must be even and ≥ 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `x`  in  dataWidth  input pixel, raster order (row-major, column 0 first).
- `inValid`  in  1  `x` is valid this cycle; sampled on every rising edge.
- `out`  out  dataWidth  pooled pixel.
- `outValid`  out  1  one-cycle strobe; `out` is valid.
- `frameDone`  out  1  one-cycle strobe, coincident with the last `outValid` of a frame.

## Operation
- State:
  - `col` counter, 0..imgWidth-1.
  - `row` counter, 0..imgHeight-1.
  - `hold` register, first pixel of the current horizontal pair.
  - Line buffer of imgWidth/2 entries × dataWidth.
- Edges with `inValid`=0 change nothing. Gaps of any length between valid samples are legal.
- Even `col`: store `x` into `hold`.
- Odd `col`: compute `pairMax = max(hold, x)`.
  - Even `row`: write `pairMax` to `lineBuf[col>>1]`. No output.
  - Odd `row`: `out <= max(pairMax, lineBuf[col>>1])` and pulse `outValid`.
- All comparisons are signed (`$signed`), dataWidth bits. There is no arithmetic, so no width growth.
- Counter advance on each valid sample:
  - `col` increments and wraps to 0 after imgWidth-1.
  - On that wrap, `row` increments and wraps to 0 after imgHeight-1.
  - Wrap of both means end of frame. The next valid sample is pixel (0,0) of a new frame; back-to-back frames need no idle cycle.
- `frameDone` pulses with the output generated from pixel (imgHeight-1, imgWidth-1).
- Outputs per frame: (imgWidth/2)·(imgHeight/2), in raster order of the pooled map.
- The line buffer needs no reset. Every entry is written in an even row before it is read in the following odd row.

## Timing
- Reset values: `out`=0, `outValid`=0, `frameDone`=0, `col`=0, `row`=0, `hold`=0.
- Latency: a window's bottom-right pixel is sampled at edge N; `outValid`/`out` are high/valid after edge N, for one cycle only.
- `out` holds its last value while `outValid`=0.
- `outValid` never asserts on two consecutive edges, because odd-column samples are at least two valid cycles apart.
- Reset asserted mid-frame: all registers clear immediately. After release, the next valid sample is treated as pixel (0,0). A partial window is never emitted.
- Reset release is synchronised externally to `clk`; the block needs no extra handling.

## Configuration
- `MAXPOOL_FUSED_RELU_EN`
  - Defined: the final result is clamped, `out <= (max < 0) ? 0 : max`. This lets the pool take pre-activation data, so the separate ReLU stage can be bypassed.
  - Undefined: `out` is the raw signed maximum. This is the normal build, fed by the ReLU stage.
- The macro changes only the output mux. Latency and handshakes are identical in both builds.

## Test plan
- **Ramp:** imgWidth=imgHeight=4, pixels 0..15 back-to-back. Required: `outValid` strobes carry 5, 7, 13, 15; `frameDone` fires with 15.
- **Negatives:** 2×2 frame {-3, -1, -7, -2}.
  - Macro undefined: `out` = 16'hFFFF (-1).
  - Macro defined: `out` = 0.
- **Gaps:** Ramp frame with `inValid` randomly low about 50% of cycles. Required: same four outputs, each one cycle after its 4th window pixel; `out` is stable between strobes.
- **Reset mid-frame:** assert `rst_n`=0 after 9 pixels of the Ramp frame, then send a full fresh Ramp frame. Required: all outputs read 0 during reset; then exactly 5, 7, 13, 15 with no stale window.
- **Back-to-back frames:** two 4×4 frames with no idle cycle, the second using values 100..115. Required: 5, 7, 13, 15 then 105, 107, 113, 115; `frameDone` fires twice.
- **Default size:** 28×28 random frame checked against a reference model. Required: exactly 196 `outValid` strobes, all values matching.
